square_root_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle square-root block: computes floor(sqrt(inputData)) over a configurable number of clock cycles using the true non-restoring algorithm, with a signed partial remainder and a final correction. It also returns the exact remainder and optionally rounds the root to nearest. It sits in the magnitude/absolute-value datapath. Throughput and timing closure are traded via BITS_PER_CYCLE instead of unrolling all iterations into one cycle.

---
 rtl/sqrt_pkg.sv | 18 +
 rtl/square_root_step.sv | 19 +
 rtl/square_root_seq.sv | 127 ++++++++++++
 tb/tb_square_root_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential square-root block: FSM encoding and
// the parameter legality check used at elaboration.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

    localparam int MIN_ROOT_WIDTH = 2;

    function automatic bit sqrt_params_ok(input int iw, input int ow, input int bpc);
        return (iw % 2 == 0) && (ow * 2 == iw) && (ow >= MIN_ROOT_WIDTH) &&
               (bpc > 0) && (ow % bpc == 0);
    endfunction

endpackage

// File: rtl/square_root_step.sv
// One non-restoring square-root iteration: shifts two radicand bits into the
// signed partial remainder, then subtracts or adds depending on the old sign.
module square_root_step #(
    parameter int W = 42
) (
    input  logic signed [W+1:0] i_r,
    input  logic        [W-1:0] i_q,
    input  logic        [1:0]   i_bits,
    output logic signed [W+1:0] o_r,
    output logic        [W-1:0] o_q
);
    localparam int RW = W + 2;

    // The wide sum is truncated back to RW bits; the true remainder always fits.
    assign o_r = i_r[W+1] ? RW'({i_r, i_bits} + {2'b00, i_q, 2'b11})
                          : RW'({i_r, i_bits} - {2'b00, i_q, 2'b01});
    assign o_q = {i_q[W-2:0], ~o_r[W+1]};

endmodule

// File: rtl/square_root_seq.sv
// Handshaked multi-cycle integer square root with exact remainder and
// optional round-to-nearest; BITS_PER_CYCLE root bits resolved per clock.
module square_root_seq
    import sqrt_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 84,
    parameter int OUTPUT_DATA_WIDTH = 42,
    parameter int BITS_PER_CYCLE    = 1,
    parameter int ROUND             = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]  inputData,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] outputData,
    output logic [OUTPUT_DATA_WIDTH:0]   remainderData,
    output logic                         busy
);
    localparam int IW  = INPUT_DATA_WIDTH;
    localparam int W   = OUTPUT_DATA_WIDTH;
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = W / BPC;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;

    if (!sqrt_params_ok(IW, W, BPC)) begin : g_param_err
        $error("square_root_seq: need even input width, output = input/2, BITS_PER_CYCLE | output width");
    end

    sqrt_state_e        r_state;
    logic [IW-1:0]      r_op;
    logic signed [W+1:0] r_r;
    logic [W-1:0]       r_q;
    logic [CW-1:0]      r_cnt;
    logic               r_out_valid;
    logic [W-1:0]       r_root;
    logic [W:0]         r_rem;

    logic signed [W+1:0] w_r [BPC+1];
    logic [W-1:0]        w_q [BPC+1];
    logic signed [W+1:0] w_rf;
    logic [W-1:0]        w_qf;
    logic [W:0]          w_rem;
    logic [W-1:0]        w_root;
    logic                w_accept;

    assign w_r[0] = r_r;
    assign w_q[0] = r_q;

    for (genvar i = 0; i < BPC; i++) begin : g_step
        square_root_step #(.W(W)) u_step (
            .i_r    (w_r[i]),
            .i_q    (w_q[i]),
            .i_bits (r_op[IW-1-2*i -: 2]),
            .o_r    (w_r[i+1]),
            .o_q    (w_q[i+1])
        );
    end

    assign w_rf = w_r[BPC];
    assign w_qf = w_q[BPC];

    // Final correction: a negative remainder is pulled back by 2Q+1, landing in [0, 2Q].
    assign w_rem = w_rf[W+1] ? (w_rf[W:0] + {w_qf, 1'b1}) : w_rf[W:0];

    if (ROUND != 0) begin : g_round
        assign w_root = ((w_rem > {1'b0, w_qf}) && !(&w_qf))
                        ? w_qf + {{(W-1){1'b0}}, 1'b1} : w_qf;
    end else begin : g_trunc
        assign w_root = w_qf;
    end

    assign in_ready      = reset_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept      = in_valid && in_ready;
    assign out_valid     = r_out_valid;
    assign outputData    = r_root;
    assign remainderData = r_rem;
    assign busy          = (r_state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_root      <= '0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) r_state <= CALC;
                end
                CALC: begin
                    r_op  <= r_op << (2 * BPC);
                    r_r   <= w_rf;
                    r_q   <= w_qf;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_root      <= w_root;
                        r_rem       <= w_rem;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= in_valid ? CALC : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Operand load shared by the IDLE and back-to-back DONE paths.
            if (w_accept) begin
                r_op  <= inputData;
                r_r   <= '0;
                r_q   <= '0;
                r_cnt <= CW'(N - 1);
            end
        end
    end

endmodule

// File: tb/tb_square_root_seq.sv
// Scoreboard bench: three instances (BPC=1 truncate, BPC=1 round, BPC=3
// truncate) checked against a binary-search integer square root model.
module tb_square_root_seq;
    localparam int IW = 84;
    localparam int OW = 42;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          iv   [3];
    logic [IW-1:0] din  [3];
    logic          ordy [3];
    logic          rdy  [3];
    logic          ov   [3];
    logic          bsy  [3];
    logic [OW-1:0] dout [3];
    logic [OW:0]   drem [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        square_root_seq #(
            .INPUT_DATA_WIDTH  (IW),
            .OUTPUT_DATA_WIDTH (OW),
            .BITS_PER_CYCLE    ((g == 2) ? 3 : 1),
            .ROUND             ((g == 1) ? 1 : 0)
        ) u_dut (
            .clock         (clk),
            .reset_n       (rst_n),
            .in_valid      (iv[g]),
            .in_ready      (rdy[g]),
            .inputData     (din[g]),
            .out_valid     (ov[g]),
            .out_ready     (ordy[g]),
            .outputData    (dout[g]),
            .remainderData (drem[g]),
            .busy          (bsy[g])
        );
    end

    typedef struct {
        int            d;
        logic [OW-1:0] root;
        logic [OW:0]   rem;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     fails  = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    function automatic logic [127:0] isqrt(input logic [IW-1:0] x);
        logic [127:0] lo, hi, mid;
        lo = 0;
        hi = (128'd1 << OW) - 1;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= {44'd0, x}) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic push_exp(input int d, input logic [IW-1:0] x);
        exp_t e;
        logic [127:0] r, rm;
        r  = isqrt(x);
        rm = {44'd0, x} - r * r;
        e.d   = d;
        e.rem = rm[OW:0];
        if (d == 1 && rm > r && r != (128'd1 << OW) - 1) e.root = OW'(r + 1);
        else e.root = r[OW-1:0];
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (rst_n === 1'b1 && ov[g] && ordy[g]) begin
                if (sb.size() == 0) chk($sformatf("spurious_out_d%0d", g), 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("result_dut", g, e.d);
                    chk($sformatf("root_d%0d", g), dout[g], e.root);
                    chk($sformatf("rem_d%0d", g), drem[g], e.rem);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [IW-1:0] x, input bit push);
        bit ok;
        iv[d]  = 1'b1;
        din[d] = x;
        if (push) push_exp(d, x);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else @(posedge clk);
        #1 iv[d] = 1'b0;
    endtask

    task automatic wait_ov(input int d, output longint t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ov[d]) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
        if (!ok) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Edges counted including the accepting one until out_valid is seen.
    task automatic latency(input int d, input logic [IW-1:0] x, input int exp_lat);
        int cnt;
        send(d, x, 1);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov[d]) break;
            @(posedge clk);
            cnt++;
        end
        chk($sformatf("latency_d%0d", d), cnt, exp_lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t1, t2;
        logic [95:0] r96;
        logic [IW-1:0] x;
        bit seen;
        for (int g = 0; g < 3; g++) begin
            iv[g] = 0; din[g] = '0; ordy[g] = 1;
        end
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_ov%0d", g), ov[g], 0);
            chk($sformatf("rst_rdy%0d", g), rdy[g], 0);
            chk($sformatf("rst_out%0d", g), dout[g], 0);
            chk($sformatf("rst_rem%0d", g), drem[g], 0);
            chk($sformatf("rst_busy%0d", g), bsy[g], 0);
        end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("idle_ready", rdy[0], 1);
        @(posedge clk); #1;

        latency(0, '0, 43);
        drain();
        send(0, 84'd1_000_000, 1);
        send(0, 84'd99, 1);
        send(0, {IW{1'b1}}, 1);
        drain();

        // Back-to-back with in_valid held high
        iv[0] = 1; din[0] = 84'd99; push_exp(0, 84'd99);
        @(negedge clk);
        chk("b2b_ready", rdy[0], 1);
        @(posedge clk); #1 din[0] = 84'd100; push_exp(0, 84'd100);
        wait_ov(0, t1);
        @(posedge clk); #1 iv[0] = 0;
        wait_ov(0, t2);
        chk("b2b_spacing", t2 - t1, 43);
        @(posedge clk); #1;
        drain();

        // Consumer stall in DONE
        ordy[0] = 0;
        send(0, 84'd99, 1);
        wait_ov(0, t1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out", dout[0], 9);
            chk("stall_rem", drem[0], 18);
            chk("stall_ov", ov[0], 1);
            chk("stall_rdy", rdy[0], 0);
        end
        @(posedge clk); #1;
        ordy[0] = 1; iv[0] = 1; din[0] = 84'd100; push_exp(0, 84'd100);
        @(negedge clk);
        chk("accept_on_release", rdy[0], 1);
        @(posedge clk); #1 iv[0] = 0;
        @(negedge clk);
        chk("calc_after_release_busy", bsy[0], 1);
        chk("calc_after_release_ov", ov[0], 0);
        @(posedge clk); #1;
        drain();

        // Round-to-nearest instance
        send(1, 84'd99, 1);
        send(1, 84'd8, 1);
        send(1, 84'd1_000_000, 1);
        send(1, {IW{1'b1}}, 1);
        drain();

        // Three bits per cycle
        latency(2, 84'd99, 15);
        drain();
        for (int i = 0; i < 1000; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            x = r96[IW-1:0];
            if (i % 4 == 1) x = x >> $urandom_range(0, IW - 1);
            send(2, x, 1);
        end
        drain();

        // Reset mid-CALC discards the pending result
        send(2, 84'd12345, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midcalc_rst_busy", bsy[2], 0);
        chk("midcalc_rst_rdy", rdy[2], 0);
        chk("midcalc_rst_ov", ov[2], 0);
        @(posedge clk); #1 rst_n = 1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov[2]) seen = 1;
        end
        chk("no_ov_after_reset", seen, 0);
        @(posedge clk); #1;
        send(2, 84'd1_000_000, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
